// File: rtl/wb_reg_bank_pkg.sv
// Shared types, defaults and helpers for the Wishbone CSR bank.
// Optional write-1-to-clear support is enabled by WB_REG_BANK_W1C_EN.
package wb_reg_bank_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 8;

  // Widest bus the lane helper supports.
  localparam int MAX_W   = 1024;
  localparam int MAX_SEL = MAX_W / 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // sel -> per-bit mask, one byte per select bit.
  function automatic logic [MAX_W-1:0] lane_mask(
    input logic [MAX_SEL-1:0] sel
  );
    logic [MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_SEL; b++)
      m[b*8 +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_reg_bank_cell.sv
// One DATA_W register: reset value, bus byte/bit-masked merge, hw load,
// optional W1C bits (WB_REG_BANK_W1C_EN). Ports: bus_we/dat/sel, hw_we/dat/set, q.
module wb_reg_bank_cell
  import wb_reg_bank_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter logic [DATA_W-1:0] WMASK   = '1,
  parameter logic              RO      = 1'b0,
  parameter logic [DATA_W-1:0] W1C     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_we,
  input  logic [DATA_W-1:0]   bus_dat,
  input  logic [DATA_W/8-1:0] bus_sel,
  input  logic                hw_we,
  input  logic [DATA_W-1:0]   hw_dat,
  input  logic [DATA_W-1:0]   hw_set,
  output logic [DATA_W-1:0]   q
);

  logic [MAX_SEL-1:0] sel_ext;
  logic [DATA_W-1:0]  lane;
  logic [DATA_W-1:0]  bmask;
  logic [DATA_W-1:0]  base;
  logic [DATA_W-1:0]  nxt;

  assign sel_ext = MAX_SEL'(bus_sel);
  assign lane    = DATA_W'(lane_mask(sel_ext));
  assign bmask   = bus_we ?
                   (lane & WMASK & {DATA_W{~RO}}) : '0;

  // hw load supplies every bit the bus does not write.
  assign base = hw_we ? hw_dat : q;

`ifdef WB_REG_BANK_W1C_EN
  logic [DATA_W-1:0] plain;
  logic [DATA_W-1:0] clr_bits;
  logic [DATA_W-1:0] set_bits;

  assign plain    = bmask & ~W1C;
  assign clr_bits = bmask & W1C & bus_dat;
  assign set_bits = hw_set & W1C;
  // set wins over clear on the same edge
  assign nxt = (((bus_dat & plain) | (base & ~plain))
               & ~clr_bits) | set_bits;
`else
  logic unused_set;
  assign unused_set = ^hw_set;
  assign nxt = (bus_dat & bmask) | (base & ~bmask);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= nxt;
  end

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone classic CSR bank: NUM_REGS registers, 1-cycle ack/err,
// byte lanes, WMASK, RO regs, hw update; W1C via WB_REG_BANK_W1C_EN.
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] WMASK     = '1,
  parameter logic [NUM_REGS-1:0]        RO_REGS   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] W1C_MASK  = '0,
  localparam int ADDR_W =
    (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [ADDR_W:0]            wb_adr_i,
  input  logic [DATA_W-1:0]          wb_dat_i,
  input  logic [DATA_W/8-1:0]        wb_sel_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic [DATA_W-1:0]          wb_dat_o,
  input  logic [NUM_REGS-1:0]        hw_we_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_dat_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set_i,
  output logic [NUM_REGS*DATA_W-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic                req;
  logic                in_range;
  logic                wr;
  logic [NUM_REGS-1:0] hit;
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   q [NUM_REGS];

  // Holding ack/err masks the request, so back-to-back
  // requests are serviced every other cycle.
  assign req      = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
  assign in_range = wb_adr_i < NREGS;
  assign wr       = req & wb_we_i & in_range;

  always_comb begin
    hit    = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_adr_i == (ADDR_W+1)'(i)) begin
        hit[i] = 1'b1;
        rd_mux = q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      wr_pulse_o <= '0;
    end else begin
      wb_ack_o   <= req & in_range;
      wb_err_o   <= req & ~in_range;
      wb_dat_o   <= (req & in_range & ~wb_we_i) ? rd_mux : '0;
      wr_pulse_o <= wr ? hit : '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    wb_reg_bank_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RESET_VAL[i*DATA_W +: DATA_W]),
      .WMASK   (WMASK[i*DATA_W +: DATA_W]),
      .RO      (RO_REGS[i]),
      .W1C     (W1C_MASK[i*DATA_W +: DATA_W])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus_we  (wr & hit[i]),
      .bus_dat (wb_dat_i),
      .bus_sel (wb_sel_i),
      .hw_we   (hw_we_i[i]),
      .hw_dat  (hw_dat_i[i*DATA_W +: DATA_W]),
      .hw_set  (hw_set_i[i*DATA_W +: DATA_W]),
      .q       (q[i])
    );
    assign reg_q_o[i*DATA_W +: DATA_W] = q[i];
  end

endmodule

// File: tb/tb_wb_reg_bank.sv
// Self-checking bench for wb_reg_bank (8 x 32-bit).
// Table-driven transfers plus hand sequences for multi-cycle cases.
module tb_wb_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   adr;
  logic [31:0]  dat_w;
  logic [3:0]   sel;
  logic         ack, err;
  logic [31:0]  dat_r;
  logic [7:0]   hw_we;
  logic [255:0] hw_dat;
  logic [255:0] hw_set;
  logic [255:0] reg_q;
  logic [7:0]   pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_reg_bank #(
    .DATA_W    (32),
    .NUM_REGS  (8),
    .RESET_VAL (256'hA5 << 64),
    .WMASK     (~(256'h1 << 31)),
    .RO_REGS   (8'h20),
    .W1C_MASK  (256'h1 << 128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_dat_o   (dat_r),
    .hw_we_i    (hw_we),
    .hw_dat_i   (hw_dat),
    .hw_set_i   (hw_set),
    .reg_q_o    (reg_q),
    .wr_pulse_o (pulse)
  );

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [7:0]  hwe;
    logic [31:0] hval;
    int          hreg;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic [7:0]  pulse;
    int          ridx;
    logic [31:0] rval;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    logic w, logic [3:0] a, logic [31:0] d, logic [3:0] s,
    logic [7:0] he, logic [31:0] hv, int hr,
    logic ea, logic ee, logic [31:0] ed, logic [7:0] ep,
    int ri, logic [31:0] rv);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s;
    v.hwe = he; v.hval = hv; v.hreg = hr;
    v.ack = ea; v.err = ee; v.rdat = ed; v.pulse = ep;
    v.ridx = ri; v.rval = rv;
    return v;
  endfunction

  function automatic logic [31:0] regv(int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; adr = '0; dat_w = '0; sel = '0;
    hw_we = '0; hw_dat = '0; hw_set = '0;
  endtask

  task automatic run_vec(int k);
    vec_t v;
    v = tbl[k];
    cyc = 1; stb = 1; we = v.we; adr = v.adr;
    dat_w = v.dat; sel = v.sel; hw_we = v.hwe;
    if (v.hwe != 0) hw_dat[v.hreg*32 +: 32] = v.hval;
    @(negedge clk);
    chk($sformatf("v%0d ack", k), 32'(ack), 32'(v.ack));
    chk($sformatf("v%0d err", k), 32'(err), 32'(v.err));
    chk($sformatf("v%0d dat", k), dat_r, v.rdat);
    chk($sformatf("v%0d pulse", k), 32'(pulse), 32'(v.pulse));
    chk($sformatf("v%0d reg%0d", k, v.ridx), regv(v.ridx), v.rval);
    idle();
    @(negedge clk);
    chk($sformatf("v%0d ack_end", k), 32'(ack | err), 32'h0);
    chk($sformatf("v%0d pulse_end", k), 32'(pulse), 32'h0);
  endtask

  initial begin
    tbl[0]  = mk(1, 4'd1, 32'h1122_3344, 4'b0101, 8'h00, 0, 0,
                 1, 0, 32'h0, 8'h02, 1, 32'h0022_0044);
    tbl[1]  = mk(0, 4'd1, 32'h0, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0022_0044, 8'h00, 1, 32'h0022_0044);
    tbl[2]  = mk(0, 4'd8, 32'h0, 4'hF, 8'h00, 0, 0,
                 0, 1, 32'h0, 8'h00, 1, 32'h0022_0044);
    tbl[3]  = mk(1, 4'd3, 32'h0, 4'b0011, 8'h08, 32'hFFFF_FFFF, 3,
                 1, 0, 32'h0, 8'h08, 3, 32'hFFFF_0000);
    tbl[4]  = mk(1, 4'd5, 32'hDEAD_BEEF, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0, 8'h20, 5, 32'h0);
    tbl[5]  = mk(1, 4'd0, 32'h8000_0000, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0, 8'h01, 0, 32'h0);
    tbl[6]  = mk(1, 4'd0, 32'h8000_00FF, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0, 8'h01, 0, 32'h0000_00FF);
    tbl[7]  = mk(1, 4'd2, 32'hFFFF_FFFF, 4'b0000, 8'h00, 0, 0,
                 1, 0, 32'h0, 8'h04, 2, 32'h0000_00A5);
    tbl[8]  = mk(1, 4'd9, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 0,
                 0, 1, 32'h0, 8'h00, 1, 32'h0022_0044);
    tbl[9]  = mk(0, 4'd2, 32'h0, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0000_00A5, 8'h00, 2, 32'h0000_00A5);
    tbl[10] = mk(0, 4'd0, 32'h0, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'h0000_00FF, 8'h00, 0, 32'h0000_00FF);
    tbl[11] = mk(0, 4'd3, 32'h0, 4'hF, 8'h00, 0, 0,
                 1, 0, 32'hFFFF_0000, 8'h00, 3, 32'hFFFF_0000);
    tbl[12] = mk(0, 4'd15, 32'h0, 4'hF, 8'h00, 0, 0,
                 0, 1, 32'h0, 8'h00, 7, 32'h0);

    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst reg2", regv(2), 32'h0000_00A5);
    chk("rst reg1", regv(1), 32'h0);
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst dat", dat_r, 32'h0);
    chk("rst pulse", 32'(pulse), 32'h0);
    rst_n = 1;
    @(negedge clk);

    for (int k = 0; k < 13; k++) run_vec(k);

    // back-to-back: ack every other cycle
    cyc = 1; stb = 1; we = 0; adr = 4'd2; sel = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b2b ack%0d", c), 32'(ack), 32'((c % 2) == 0));
      chk($sformatf("b2b dat%0d", c), dat_r,
          ((c % 2) == 0) ? 32'h0000_00A5 : 32'h0);
    end
    idle();
    @(negedge clk);

    // strobe never asserted: nothing sampled, never acked later
    cyc = 1; stb = 0; we = 1; adr = 4'd7;
    dat_w = 32'hFFFF_FFFF; sel = 4'hF;
    @(negedge clk);
    chk("abort ack", 32'(ack), 32'h0);
    idle();
    @(negedge clk);
    chk("abort ack_late", 32'(ack), 32'h0);
    chk("abort reg7", regv(7), 32'h0);

    // hw-only load
    hw_we = 8'h40; hw_dat[6*32 +: 32] = 32'h1234_5678;
    @(negedge clk);
    idle();
    chk("hw reg6", regv(6), 32'h1234_5678);

`ifdef WB_REG_BANK_W1C_EN
    hw_set[4*32] = 1'b1;
    @(negedge clk);
    idle();
    chk("w1c set", regv(4), 32'h1);
    cyc = 1; stb = 1; we = 1; adr = 4'd4;
    dat_w = 32'h0; sel = 4'hF;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("w1c write0", regv(4), 32'h1);
    cyc = 1; stb = 1; we = 1; adr = 4'd4;
    dat_w = 32'h1; sel = 4'hF;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("w1c clear", regv(4), 32'h0);
    cyc = 1; stb = 1; we = 1; adr = 4'd4;
    dat_w = 32'h1; sel = 4'hF; hw_set[4*32] = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("w1c set_wins", regv(4), 32'h1);
`else
    hw_set[4*32] = 1'b1;
    @(negedge clk);
    idle();
    chk("plain hw_set", regv(4), 32'h0);
    cyc = 1; stb = 1; we = 1; adr = 4'd4;
    dat_w = 32'h1; sel = 4'hF;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("plain write1", regv(4), 32'h1);
`endif

    // transfer on a reset edge is dropped
    rst_n = 0;
    cyc = 1; stb = 1; we = 1; adr = 4'd7;
    dat_w = 32'hCAFE_F00D; sel = 4'hF;
    @(negedge clk);
    chk("rstx ack", 32'(ack), 32'h0);
    chk("rstx pulse", 32'(pulse), 32'h0);
    chk("rstx reg7", regv(7), 32'h0);
    chk("rstx reg0", regv(0), 32'h0);
    chk("rstx reg2", regv(2), 32'h0000_00A5);
    idle();
    rst_n = 1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
